// File: rtl/axi_ddr3_traffic_gen.sv
// axi_ddr3_traffic_gen: AXI4 write/read-back traffic generator.
// Writes NUM_BURSTS INCR bursts of LFSR data. It then reads them back,
// counts bad responses and data mismatches, and reports pass/fail.
// Optional backpressure: define TRAFFIC_GEN_THROTTLE_EN to gate wvalid
// (between beats) and rready with a free-running 3-bit LFSR.
// Handshake rule on every channel: a transfer happens on a rising clock edge
// where valid and ready are both high. A valid, once raised, holds its payload
// stable until that edge.
module axi_ddr3_traffic_gen #(
  parameter int               WIDTH      = 32,
  parameter int               ADDRS      = 27,
  parameter int               REQID      = 4,
  parameter int               BURST_LEN  = 4,
  parameter int               NUM_BURSTS = 16,
  parameter logic [ADDRS-1:0] BASE_ADDR  = '0,
  parameter logic [31:0]      SEED       = 32'hACE1_2345
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               pass_o,
  output logic [15:0]        errors_o,
  output logic               axi_awvalid_o,
  input  logic               axi_awready_i,
  output logic [ADDRS-1:0]   axi_awaddr_o,
  output logic [REQID-1:0]   axi_awid_o,
  output logic [7:0]         axi_awlen_o,
  output logic [1:0]         axi_awburst_o,
  output logic               axi_wvalid_o,
  input  logic               axi_wready_i,
  output logic               axi_wlast_o,
  output logic [WIDTH/8-1:0] axi_wstrb_o,
  output logic [WIDTH-1:0]   axi_wdata_o,
  input  logic               axi_bvalid_i,
  output logic               axi_bready_o,
  input  logic [1:0]         axi_bresp_i,
  input  logic [REQID-1:0]   axi_bid_i,
  output logic               axi_arvalid_o,
  input  logic               axi_arready_i,
  output logic [ADDRS-1:0]   axi_araddr_o,
  output logic [REQID-1:0]   axi_arid_o,
  output logic [7:0]         axi_arlen_o,
  output logic [1:0]         axi_arburst_o,
  input  logic               axi_rvalid_i,
  output logic               axi_rready_o,
  input  logic               axi_rlast_i,
  input  logic [1:0]         axi_rresp_i,
  input  logic [REQID-1:0]   axi_rid_i,
  input  logic [WIDTH-1:0]   axi_rdata_i,
  output logic [2:0]         dbg_state_o
);

  localparam int NW          = WIDTH / 32;
  localparam int BURST_BYTES = BURST_LEN * WIDTH / 8;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WR_ADDR = 3'd1,
    S_WR_DATA = 3'd2,
    S_WR_RESP = 3'd3,
    S_RD_ADDR = 3'd4,
    S_RD_DATA = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t           state;
  logic [15:0]      burst_n;
  logic [ADDRS-1:0] burst_addr;
  logic [31:0]      lfsr;
  logic [7:0]       beat_cnt;
  logic             gate;

  // Galois LFSR, x^32+x^22+x^2+x+1, shifting right.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // One beat is NW consecutive LFSR words, word 0 in the LSBs.
  function automatic logic [WIDTH-1:0] beat_of(input logic [31:0] s);
    logic [31:0]      w;
    logic [WIDTH-1:0] r;
    w = s;
    r = '0;
    for (int i = 0; i < NW; i++) begin
      r[i*32 +: 32] = w;
      w = lfsr_step(w);
    end
    return r;
  endfunction

  function automatic logic [31:0] lfsr_adv(input logic [31:0] s);
    logic [31:0] w;
    w = s;
    for (int i = 0; i < NW; i++) w = lfsr_step(w);
    return w;
  endfunction

`ifdef TRAFFIC_GEN_THROTTLE_EN
  logic [2:0] thr;
  // Free-running 3-bit LFSR (x^3+x^2+1); holds valid/ready low on 2 of 7 states.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) thr <= 3'b001;
    else          thr <= {thr[1:0], thr[2] ^ thr[1]};
  end
  assign gate = (thr[1:0] == 2'b01);
`else
  assign gate = 1'b0;
`endif

  logic [REQID-1:0] cur_id;
  logic             last_burst, last_beat, b_hs, r_hs, b_bad, r_bad, err_hit;
  logic [WIDTH-1:0] cur_beat;
  logic [15:0]      errors_next;

  // Per-cycle response checks and the saturating error increment.
  always_comb begin
    cur_id      = REQID'(burst_n);
    last_burst  = (burst_n == 16'(NUM_BURSTS - 1));
    last_beat   = (beat_cnt == 8'(BURST_LEN - 1));
    cur_beat    = beat_of(lfsr);
    b_hs        = axi_bvalid_i && axi_bready_o;
    r_hs        = axi_rvalid_i && axi_rready_o;
    b_bad       = (axi_bresp_i != 2'b00) || (axi_bid_i != cur_id);
    r_bad       = (axi_rdata_i != cur_beat) || (axi_rresp_i != 2'b00) ||
                  (axi_rid_i != cur_id) || (axi_rlast_i != last_beat);
    err_hit     = ((state == S_WR_RESP) && b_hs && b_bad) ||
                  ((state == S_RD_DATA) && r_hs && r_bad);
    errors_next = errors_o;
    if (err_hit && (errors_o != 16'hFFFF)) errors_next = errors_o + 16'd1;
  end

  assign dbg_state_o = state;

  // Main run sequencer; every output is a register written here.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= S_IDLE;
      burst_n       <= '0;
      burst_addr    <= '0;
      lfsr          <= '0;
      beat_cnt      <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      errors_o      <= '0;
      axi_awvalid_o <= 1'b0;
      axi_awaddr_o  <= '0;
      axi_awid_o    <= '0;
      axi_awlen_o   <= '0;
      axi_awburst_o <= '0;
      axi_wvalid_o  <= 1'b0;
      axi_wlast_o   <= 1'b0;
      axi_wstrb_o   <= '0;
      axi_wdata_o   <= '0;
      axi_bready_o  <= 1'b0;
      axi_arvalid_o <= 1'b0;
      axi_araddr_o  <= '0;
      axi_arid_o    <= '0;
      axi_arlen_o   <= '0;
      axi_arburst_o <= '0;
      axi_rready_o  <= 1'b0;
    end else begin
      done_o   <= 1'b0;
      errors_o <= errors_next;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            errors_o   <= '0;
            pass_o     <= 1'b0;
            burst_n    <= '0;
            burst_addr <= BASE_ADDR;
            lfsr       <= SEED;
            busy_o     <= 1'b1;
            state      <= S_WR_ADDR;
          end
        end
        S_WR_ADDR: begin
          if (!axi_awvalid_o) begin
            axi_awvalid_o <= 1'b1;
            axi_awaddr_o  <= burst_addr;
            axi_awid_o    <= cur_id;
            axi_awlen_o   <= 8'(BURST_LEN - 1);
            axi_awburst_o <= 2'b01;
          end else if (axi_awready_i) begin
            axi_awvalid_o <= 1'b0;
            axi_wvalid_o  <= 1'b1;
            axi_wdata_o   <= cur_beat;
            axi_wstrb_o   <= '1;
            axi_wlast_o   <= (BURST_LEN == 1);
            beat_cnt      <= '0;
            state         <= S_WR_DATA;
          end
        end
        S_WR_DATA: begin
          if (axi_wvalid_o && axi_wready_i) begin
            lfsr <= lfsr_adv(lfsr);
            if (last_beat) begin
              axi_wvalid_o <= 1'b0;
              axi_wlast_o  <= 1'b0;
              axi_bready_o <= 1'b1;
              state        <= S_WR_RESP;
            end else begin
              beat_cnt     <= beat_cnt + 8'd1;
              axi_wdata_o  <= beat_of(lfsr_adv(lfsr));
              axi_wlast_o  <= ((beat_cnt + 8'd1) == 8'(BURST_LEN - 1));
              axi_wvalid_o <= !gate;
            end
          end else if (!axi_wvalid_o && !gate) begin
            axi_wvalid_o <= 1'b1;
          end
        end
        S_WR_RESP: begin
          if (b_hs) begin
            axi_bready_o <= 1'b0;
            if (last_burst) begin
              burst_n    <= '0;
              burst_addr <= BASE_ADDR;
              lfsr       <= SEED;
              state      <= S_RD_ADDR;
            end else begin
              burst_n    <= burst_n + 16'd1;
              burst_addr <= burst_addr + ADDRS'(BURST_BYTES);
              state      <= S_WR_ADDR;
            end
          end
        end
        S_RD_ADDR: begin
          if (!axi_arvalid_o) begin
            axi_arvalid_o <= 1'b1;
            axi_araddr_o  <= burst_addr;
            axi_arid_o    <= cur_id;
            axi_arlen_o   <= 8'(BURST_LEN - 1);
            axi_arburst_o <= 2'b01;
          end else if (axi_arready_i) begin
            axi_arvalid_o <= 1'b0;
            axi_rready_o  <= !gate;
            beat_cnt      <= '0;
            state         <= S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          axi_rready_o <= !gate;
          if (r_hs) begin
            lfsr <= lfsr_adv(lfsr);
            if (last_beat) begin
              axi_rready_o <= 1'b0;
              if (last_burst) begin
                busy_o <= 1'b0;
                done_o <= 1'b1;
                pass_o <= (errors_next == 16'd0);
                state  <= S_DONE;
              end else begin
                burst_n    <= burst_n + 16'd1;
                burst_addr <= burst_addr + ADDRS'(BURST_BYTES);
                state      <= S_RD_ADDR;
              end
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_ddr3_traffic_gen.sv
// Bench for axi_ddr3_traffic_gen: memory-backed AXI slave with fault and stall
// knobs, a reference model of the write data stream and burst addresses, and
// directed runs covering clean, corrupted, bad-response, reset-abort and
// stalled traffic.
module tb_axi_ddr3_traffic_gen;

  localparam int WIDTH = 32;
  localparam int ADDRS = 27;
  localparam int REQID = 4;
  localparam int BL    = 4;
  localparam int NB    = 4;
  localparam logic [31:0] SEED = 32'hACE1_2345;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset_n;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic               start_i;
  logic               busy_o, done_o, pass_o;
  logic [15:0]        errors_o;
  logic               axi_awvalid_o, axi_awready_i;
  logic [ADDRS-1:0]   axi_awaddr_o;
  logic [REQID-1:0]   axi_awid_o;
  logic [7:0]         axi_awlen_o;
  logic [1:0]         axi_awburst_o;
  logic               axi_wvalid_o, axi_wready_i, axi_wlast_o;
  logic [WIDTH/8-1:0] axi_wstrb_o;
  logic [WIDTH-1:0]   axi_wdata_o;
  logic               axi_bvalid_i, axi_bready_o;
  logic [1:0]         axi_bresp_i;
  logic [REQID-1:0]   axi_bid_i;
  logic               axi_arvalid_o, axi_arready_i;
  logic [ADDRS-1:0]   axi_araddr_o;
  logic [REQID-1:0]   axi_arid_o;
  logic [7:0]         axi_arlen_o;
  logic [1:0]         axi_arburst_o;
  logic               axi_rvalid_i, axi_rready_o, axi_rlast_i;
  logic [1:0]         axi_rresp_i;
  logic [REQID-1:0]   axi_rid_i;
  logic [WIDTH-1:0]   axi_rdata_i;
  logic [2:0]         dbg_state_o;

  axi_ddr3_traffic_gen #(
    .WIDTH(WIDTH), .ADDRS(ADDRS), .REQID(REQID), .BURST_LEN(BL),
    .NUM_BURSTS(NB), .BASE_ADDR('0), .SEED(SEED)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start_i(start_i),
    .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o), .errors_o(errors_o),
    .axi_awvalid_o(axi_awvalid_o), .axi_awready_i(axi_awready_i),
    .axi_awaddr_o(axi_awaddr_o), .axi_awid_o(axi_awid_o),
    .axi_awlen_o(axi_awlen_o), .axi_awburst_o(axi_awburst_o),
    .axi_wvalid_o(axi_wvalid_o), .axi_wready_i(axi_wready_i),
    .axi_wlast_o(axi_wlast_o), .axi_wstrb_o(axi_wstrb_o), .axi_wdata_o(axi_wdata_o),
    .axi_bvalid_i(axi_bvalid_i), .axi_bready_o(axi_bready_o),
    .axi_bresp_i(axi_bresp_i), .axi_bid_i(axi_bid_i),
    .axi_arvalid_o(axi_arvalid_o), .axi_arready_i(axi_arready_i),
    .axi_araddr_o(axi_araddr_o), .axi_arid_o(axi_arid_o),
    .axi_arlen_o(axi_arlen_o), .axi_arburst_o(axi_arburst_o),
    .axi_rvalid_i(axi_rvalid_i), .axi_rready_o(axi_rready_o),
    .axi_rlast_i(axi_rlast_i), .axi_rresp_i(axi_rresp_i),
    .axi_rid_i(axi_rid_i), .axi_rdata_i(axi_rdata_i),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference data stream: successive states of x^32+x^22+x^2+x+1 from SEED.
  function automatic logic [31:0] model_next(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
  endfunction

  // ---------------- slave model ----------------
  int aw_stall = 0, w_stall = 0;
  bit bad_bresp = 0, flip_en = 0;
  int aw_wait, w_wait, w_beat, r_beat, rd_burst, ar_hs_count, inj_count;
  bit b_pend, r_act, r_flip;
  logic [ADDRS-1:0] wr_addr, rd_addr;
  logic [REQID-1:0] wr_id, rd_id;
  logic [31:0] mem [int];

  task automatic slave_reset();
    axi_awready_i = 0; axi_wready_i = 0; axi_bvalid_i = 0; axi_bresp_i = 0;
    axi_bid_i = 0; axi_arready_i = 0; axi_rvalid_i = 0; axi_rlast_i = 0;
    axi_rresp_i = 0; axi_rid_i = 0; axi_rdata_i = 0;
    aw_wait = 0; w_wait = 0; w_beat = 0; r_beat = 0; b_pend = 0; r_act = 0;
    wr_addr = 0; rd_addr = 0; wr_id = 0; rd_id = 0;
  endtask

  // Chooses slave inputs for the coming rising edge and books the transfers
  // that edge will complete.
  task automatic slave_cycle();
    int a;
    // B before W so a response never precedes its last data beat.
    axi_bvalid_i = b_pend;
    axi_bid_i    = wr_id;
    axi_bresp_i  = bad_bresp ? 2'b10 : 2'b00;
    if (axi_bvalid_i && axi_bready_o) begin
      b_pend = 0;
      if (bad_bresp) inj_count++;
    end
    if (axi_wvalid_o && w_wait < w_stall) begin
      axi_wready_i = 0; w_wait++;
    end else axi_wready_i = axi_wvalid_o;
    if (axi_wvalid_o && axi_wready_i) begin
      mem[int'(wr_addr) + w_beat*4] = axi_wdata_o;
      w_beat++; w_wait = 0;
      if (axi_wlast_o) b_pend = 1;
    end
    if (axi_awvalid_o && aw_wait < aw_stall) begin
      axi_awready_i = 0; aw_wait++;
    end else axi_awready_i = axi_awvalid_o;
    if (axi_awvalid_o && axi_awready_i) begin
      wr_addr = axi_awaddr_o; wr_id = axi_awid_o; w_beat = 0; aw_wait = 0;
    end
    // R before AR so data follows its address by at least one cycle.
    a = int'(rd_addr) + r_beat*4;
    axi_rvalid_i = r_act;
    axi_rid_i    = rd_id;
    axi_rresp_i  = 2'b00;
    axi_rlast_i  = r_act && (r_beat == BL-1);
    axi_rdata_i  = (r_act && mem.exists(a)) ? mem[a] : '0;
    r_flip = flip_en && r_act && (rd_burst == 1) && (r_beat == 2);
    if (r_flip) axi_rdata_i = axi_rdata_i ^ 32'h1;
    if (axi_rvalid_i && axi_rready_o) begin
      if (r_flip) inj_count++;
      r_beat++;
      if (r_beat == BL) r_act = 0;
    end
    axi_arready_i = axi_arvalid_o;
    if (axi_arvalid_o && axi_arready_i) begin
      rd_addr = axi_araddr_o; rd_id = axi_arid_o; r_beat = 0; r_act = 1;
      rd_burst = ar_hs_count; ar_hs_count++;
    end
  endtask

  // ---------------- compare process ----------------
  int aw_cnt, ar_cnt, wbeat_mon, w_cnt, done_cnt, busy_cyc;
  bit aw_hold, w_hold;
  logic [ADDRS-1:0] aw_addr_prev;
  logic [WIDTH-1:0] w_data_prev;
  logic w_last_prev;
  logic [ADDRS-1:0] aw_log [0:7];
  logic [REQID-1:0] awid_log [0:7];
  logic [WIDTH-1:0] w_log [0:7];

  task automatic compare_cycle();
    logic [WIDTH-1:0] exp;
    if (busy_o) busy_cyc++;
    if (done_o) begin
      done_cnt++;
      check("done_errors", errors_o, inj_count);
      check("done_pass", pass_o, inj_count == 0);
    end
    if (aw_hold) begin
      check("aw_hold_valid", axi_awvalid_o, 1);
      check("aw_hold_addr", axi_awaddr_o, aw_addr_prev);
    end
    if (w_hold) begin
      check("w_hold_valid", axi_wvalid_o, 1);
      check("w_hold_data", axi_wdata_o, w_data_prev);
      check("w_hold_last", axi_wlast_o, w_last_prev);
    end
    aw_hold = axi_awvalid_o && !axi_awready_i;
    aw_addr_prev = axi_awaddr_o;
    w_hold = axi_wvalid_o && !axi_wready_i;
    w_data_prev = axi_wdata_o;
    w_last_prev = axi_wlast_o;
    if (axi_awvalid_o && axi_awready_i) begin
      check("aw_addr", axi_awaddr_o, ADDRS'(aw_cnt * BL * WIDTH / 8));
      check("aw_id", axi_awid_o, REQID'(aw_cnt));
      check("aw_len", axi_awlen_o, BL - 1);
      check("aw_burst", axi_awburst_o, 2'b01);
      if (aw_cnt < 8) begin
        aw_log[aw_cnt] = axi_awaddr_o; awid_log[aw_cnt] = axi_awid_o;
      end
      aw_cnt++;
    end
    if (axi_wvalid_o && axi_wready_i) begin
      if (exp_q.size() == 0) check("w_extra_beat", 1, 0);
      else begin
        exp = exp_q.pop_front();
        check("w_data", axi_wdata_o, exp);
      end
      check("w_last", axi_wlast_o, wbeat_mon == BL-1);
      check("w_strb", axi_wstrb_o, 4'hF);
      if (w_cnt < 8) w_log[w_cnt] = axi_wdata_o;
      w_cnt++;
      wbeat_mon = (wbeat_mon + 1) % BL;
    end
    if (axi_arvalid_o && axi_arready_i) begin
      check("ar_addr", axi_araddr_o, ADDRS'(ar_cnt * BL * WIDTH / 8));
      check("ar_id", axi_arid_o, REQID'(ar_cnt));
      check("ar_len", axi_arlen_o, BL - 1);
      check("ar_burst", axi_arburst_o, 2'b01);
      ar_cnt++;
    end
  endtask

  always @(negedge clock) begin
    if (!reset_n) begin
      slave_reset();
      aw_hold = 0; w_hold = 0;
    end else begin
      slave_cycle();
      compare_cycle();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clock); #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_done"}, done_o, 0);
    check({tag, "_pass"}, pass_o, 0);
    check({tag, "_errors"}, errors_o, 0);
    check({tag, "_aw"}, {axi_awvalid_o, axi_awaddr_o, axi_awid_o, axi_awlen_o, axi_awburst_o}, 0);
    check({tag, "_w"}, {axi_wvalid_o, axi_wlast_o, axi_wstrb_o, axi_wdata_o}, 0);
    check({tag, "_ar"}, {axi_arvalid_o, axi_araddr_o, axi_arid_o, axi_arlen_o, axi_arburst_o}, 0);
    check({tag, "_ready"}, {axi_bready_o, axi_rready_o}, 0);
  endtask

  task automatic start_run(input bit flip, input bit badb, input int stall);
    logic [31:0] w;
    exp_q.delete();
    w = SEED;
    for (int i = 0; i < NB*BL; i++) begin
      exp_q.push_back(w);
      w = model_next(w);
    end
    flip_en = flip; bad_bresp = badb; aw_stall = stall; w_stall = stall;
    aw_cnt = 0; ar_cnt = 0; wbeat_mon = 0; w_cnt = 0; done_cnt = 0;
    busy_cyc = 0; inj_count = 0; ar_hs_count = 0; rd_burst = 0;
    mem.delete();
    start_i = 1;
    tick();
    start_i = 0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bool_wait: begin
      for (int i = 0; i < budget; i++) begin
        tick();
        if (done_cnt > 0) disable bool_wait;
      end
      check({tag, "_done_timeout"}, 1, 0);
    end
    repeat (3) tick();
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_aw_bursts"}, aw_cnt, NB);
    check({tag, "_ar_bursts"}, ar_cnt, NB);
    check({tag, "_w_left"}, exp_q.size(), 0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    start_i = 0;
    reset_n = 0;
    slave_reset();
    repeat (3) tick();
    check_all_zero("reset");
    reset_n = 1;
    repeat (2) tick();

    // Clean zero-wait run.
    start_run(0, 0, 0);
    check("clean_start_busy", busy_o, 1);
    wait_done("clean", 500);
    check("clean_errors", errors_o, 0);
    check("clean_pass", pass_o, 1);
    check("clean_aw0_addr", aw_log[0], 27'h00);
    check("clean_aw1_addr", aw_log[1], 27'h10);
    check("clean_aw0_id", awid_log[0], 0);
    check("clean_aw1_id", awid_log[1], 1);
    check("clean_w0", w_log[0], 32'hACE1_2345);
    check("clean_w1", w_log[1], 32'hD650_91A1);
    check("clean_w2", w_log[2], 32'hEB08_48D3);
`ifndef TRAFFIC_GEN_THROTTLE_EN
    check("clean_run_cycles", busy_cyc + 2, NB*(BL+3) + NB*(BL+2) + 2);
`endif
    repeat (5) tick();
    check("clean_pass_held", pass_o, 1);
    check("clean_idle_busy", busy_o, 0);

    // Bit 0 of beat 2 of burst 1 corrupted on read-back.
    start_run(1, 0, 0);
    check("flip_start_pass_cleared", pass_o, 0);
    wait_done("flip", 500);
    check("flip_errors", errors_o, 1);
    check("flip_pass", pass_o, 0);

    // Every write response is SLVERR.
    start_run(0, 1, 0);
    check("bresp_start_errors_cleared", errors_o, 0);
    wait_done("bresp", 500);
    check("bresp_errors", errors_o, 4);
    check("bresp_pass", pass_o, 0);

    // Reset during the write data phase, then a fresh run.
    start_run(0, 0, 0);
    abort_wait: begin
      for (int i = 0; i < 50; i++) begin
        tick();
        if (axi_wvalid_o) disable abort_wait;
      end
      check("abort_wvalid_timeout", 1, 0);
    end
    tick();
    reset_n = 0;
    #1;
    check_all_zero("abort_async");
    tick();
    check_all_zero("abort_held");
    reset_n = 1;
    tick();
    start_run(0, 0, 0);
    wait_done("rerun", 500);
    check("rerun_errors", errors_o, 0);
    check("rerun_pass", pass_o, 1);
    check("rerun_w0", w_log[0], 32'hACE1_2345);
    check("rerun_w1", w_log[1], 32'hD650_91A1);

    // Slave stalls AW and W by 3 cycles; a stray start mid-run is ignored.
    start_run(0, 0, 3);
    repeat (10) tick();
    start_i = 1;
    tick();
    start_i = 0;
    wait_done("stall", 2000);
    check("stall_errors", errors_o, 0);
    check("stall_pass", pass_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
